// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control sequencer and its decode table.
`timescale 1ns/1ps
package mips_ctrl_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_FR    = 6'h11;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // RTYPE function codes, instr[5:0]
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // FR-class function codes
  localparam logic [5:0] FN_FADD  = 6'h00;
  localparam logic [5:0] FN_FSUB  = 6'h01;

  // FR format field, instr[25:21]
  localparam logic [4:0] FMT_SINGLE = 5'h10;
  localparam logic [4:0] FMT_DOUBLE = 5'h11;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;

  // Register write-data source
  localparam logic [2:0] WD3_MEM = 3'd0;
  localparam logic [2:0] WD3_ALU = 3'd1;
  localparam logic [2:0] WD3_HI  = 3'd2;
  localparam logic [2:0] WD3_LO  = 3'd3;
  localparam logic [2:0] WD3_FPU = 3'd4;

  // Next-PC source
  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_REG    = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;

  // Destination register select
  localparam logic [1:0] RWA_RT = 2'd0;
  localparam logic [1:0] RWA_RA = 2'd1;
  localparam logic [1:0] RWA_RD = 2'd2;
  localparam logic [1:0] RWA_FD = 2'd3;

  // ALU B-operand select
  localparam logic [1:0] MUXB_IMM  = 2'd0;
  localparam logic [1:0] MUXB_REG  = 2'd1;
  localparam logic [1:0] MUXB_LINK = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MULT_BUSY = 2'd1,
    ST_FPU_WAIT  = 2'd2,
    ST_FPU_WB    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_SINGLE  = 2'd0,
    CLS_MULT    = 2'd1,
    CLS_FPU     = 2'd2,
    CLS_ILLEGAL = 2'd3
  } instr_class_t;

  // Decoded control bundle; branches carry flags resolved against zero later
  typedef struct packed {
    logic       reg_write;
    logic       mux_a_en;
    logic       dm_we;
    logic       multiply_en;
    logic       fp_en;
    logic [1:0] mux_b_en;
    logic [1:0] rwa_sel;
    logic [1:0] mux_pc;
    logic [2:0] alu_op;
    logic [2:0] mux_wd3;
    logic       fpu_start;
    logic       fpu_op;
    logic       fpu_dbl;
    logic       br_eq;
    logic       br_ne;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_table.sv
// Pure combinational opcode/funct/fmt decode into a control bundle and class.
`timescale 1ns/1ps
module ctrl_decode_table
  import mips_ctrl_pkg::*;
#(
  parameter int SUPPORT_DOUBLE = 1
) (
  input  logic [5:0]   i_opcode,
  input  logic [5:0]   i_funct,
  input  logic [4:0]   i_fmt,
  output ctrl_t        o_ctrl,
  output instr_class_t o_class
);

  logic w_fmt_ok;
  logic w_fr_funct_ok;

  assign w_fmt_ok      = (i_fmt == FMT_SINGLE) ||
                         ((SUPPORT_DOUBLE != 0) && (i_fmt == FMT_DOUBLE));
  assign w_fr_funct_ok = (i_funct == FN_FADD) || (i_funct == FN_FSUB);

  // Decode table; anything not matched stays all-zero and is classed illegal
  always_comb begin
    o_ctrl  = '0;
    o_class = CLS_ILLEGAL;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD, FN_SUB, FN_SLT: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.mux_b_en  = MUXB_REG;
            o_ctrl.rwa_sel   = RWA_RD;
            o_ctrl.mux_wd3   = WD3_ALU;
            o_ctrl.alu_op    = (i_funct == FN_ADD) ? ALU_ADD :
                               (i_funct == FN_SUB) ? ALU_SUB : ALU_SLT;
            o_class          = CLS_SINGLE;
          end
          FN_JR: begin
            o_ctrl.mux_pc = PC_REG;
            o_class       = CLS_SINGLE;
          end
          FN_MFHI, FN_MFLO: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.rwa_sel   = RWA_RD;
            o_ctrl.mux_wd3   = (i_funct == FN_MFHI) ? WD3_HI : WD3_LO;
            o_class          = CLS_SINGLE;
          end
          FN_MULT: begin
            o_ctrl.multiply_en = 1'b1;
            o_class            = CLS_MULT;
          end
          default: ;
        endcase
      end
      OP_LW: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.mux_wd3   = WD3_MEM;
        o_ctrl.alu_op    = ALU_ADD;
        o_class          = CLS_SINGLE;
      end
      OP_SW: begin
        o_ctrl.dm_we = 1'b1;
        o_class      = CLS_SINGLE;
      end
      OP_BEQ, OP_BNE: begin
        o_ctrl.alu_op   = ALU_SUB;
        o_ctrl.mux_b_en = MUXB_REG;
        o_ctrl.br_eq    = (i_opcode == OP_BEQ);
        o_ctrl.br_ne    = (i_opcode == OP_BNE);
        o_class         = CLS_SINGLE;
      end
      OP_ADDI, OP_XORI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.mux_wd3   = WD3_ALU;
        o_ctrl.alu_op    = (i_opcode == OP_ADDI) ? ALU_ADD : ALU_XOR;
        o_class          = CLS_SINGLE;
      end
      OP_J: begin
        o_ctrl.mux_pc = PC_JUMP;
        o_class       = CLS_SINGLE;
      end
      OP_JAL: begin
        o_ctrl.mux_pc    = PC_JUMP;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.mux_a_en  = 1'b1;
        o_ctrl.mux_b_en  = MUXB_LINK;
        o_ctrl.rwa_sel   = RWA_RA;
        o_class          = CLS_SINGLE;
      end
      OP_FR: begin
        if (w_fr_funct_ok && w_fmt_ok) begin
          o_ctrl.fpu_start = 1'b1;
          o_ctrl.fpu_op    = i_funct[0];
          o_ctrl.fpu_dbl   = (i_fmt == FMT_DOUBLE);
          o_ctrl.fp_en     = 1'b1;
          o_class          = CLS_FPU;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: decode table wrapped with FSM, MULT occupancy
// counter, FPU start/done handshake with timeout, and output gating.
`timescale 1ns/1ps
module control_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES    = 4,
  parameter int FPU_TIMEOUT    = 64,
  parameter int SUPPORT_DOUBLE = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] functcode,
  input  logic [4:0] fmt,
  input  logic       zero,
  input  logic       fpu_done,
  output logic       regWrite,
  output logic       muxA_en,
  output logic       dm_we,
  output logic       multiplyEn,
  output logic       FloatingPointEn,
  output logic [1:0] muxB_en,
  output logic [1:0] regWriteAddSelect,
  output logic [1:0] muxPC,
  output logic [2:0] ALUop,
  output logic [2:0] muxWD3_en,
  output logic       fpu_start,
  output logic       fpu_op,
  output logic       fpu_dbl,
  output logic       stall,
  output logic       illegal
);

  localparam int MCW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam int TCW = $clog2(FPU_TIMEOUT);
  localparam logic [MCW-1:0] MULT_LOAD = MCW'(MULT_CYCLES - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(FPU_TIMEOUT - 1);

  state_t         r_state, w_state_next;
  logic           r_active;
  logic [MCW-1:0] r_mult_cnt, w_mult_cnt_next;
  logic [TCW-1:0] r_to_cnt, w_to_cnt_next;
  logic           r_fpu_op, w_fpu_op_next;
  logic           r_fpu_dbl, w_fpu_dbl_next;

  ctrl_t          w_dec;
  instr_class_t   w_class;
  logic           w_ready;
  logic           w_accept;
  logic           w_timeout;

  ctrl_decode_table #(
    .SUPPORT_DOUBLE(SUPPORT_DOUBLE)
  ) u_decode (
    .i_opcode (opcode),
    .i_funct  (functcode),
    .i_fmt    (fmt),
    .o_ctrl   (w_dec),
    .o_class  (w_class)
  );

  // r_active holds the front end off until the first edge after reset release
  assign w_ready   = r_active && (r_state == ST_IDLE);
  assign w_accept  = instr_valid && w_ready;
  assign w_timeout = (r_state == ST_FPU_WAIT) && !fpu_done && (r_to_cnt == TO_LAST);

  // State, counters and latched FP op/format
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_active   <= 1'b0;
      r_mult_cnt <= '0;
      r_to_cnt   <= '0;
      r_fpu_op   <= 1'b0;
      r_fpu_dbl  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_active   <= 1'b1;
      r_mult_cnt <= w_mult_cnt_next;
      r_to_cnt   <= w_to_cnt_next;
      r_fpu_op   <= w_fpu_op_next;
      r_fpu_dbl  <= w_fpu_dbl_next;
    end
  end

  // Next-state and counter update
  always_comb begin
    w_state_next    = r_state;
    w_mult_cnt_next = r_mult_cnt;
    w_to_cnt_next   = r_to_cnt;
    w_fpu_op_next   = r_fpu_op;
    w_fpu_dbl_next  = r_fpu_dbl;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_class == CLS_MULT) begin
            w_mult_cnt_next = MULT_LOAD;
            // A one-cycle multiplier needs no busy state at all
            if (MULT_LOAD != '0) w_state_next = ST_MULT_BUSY;
          end else if (w_class == CLS_FPU) begin
            w_fpu_op_next  = w_dec.fpu_op;
            w_fpu_dbl_next = w_dec.fpu_dbl;
            w_to_cnt_next  = '0;
            w_state_next   = ST_FPU_WAIT;
          end
        end
      end
      ST_MULT_BUSY: begin
        w_mult_cnt_next = r_mult_cnt - MCW'(1);
        if (r_mult_cnt <= MCW'(1)) w_state_next = ST_IDLE;
      end
      ST_FPU_WAIT: begin
        // fpu_done takes priority over a coincident timeout
        if (fpu_done)       w_state_next = ST_FPU_WB;
        else if (w_timeout) w_state_next = ST_IDLE;
        else                w_to_cnt_next = r_to_cnt + TCW'(1);
      end
      ST_FPU_WB: begin
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output decode: accepted-instruction controls in IDLE, FP writeback, pulses
  always_comb begin
    instr_ready       = w_ready;
    stall             = r_active && (r_state != ST_IDLE);
    regWrite          = 1'b0;
    muxA_en           = 1'b0;
    dm_we             = 1'b0;
    multiplyEn        = 1'b0;
    FloatingPointEn   = 1'b0;
    muxB_en           = '0;
    regWriteAddSelect = '0;
    muxPC             = PC_SEQ;
    ALUop             = '0;
    muxWD3_en         = '0;
    fpu_start         = 1'b0;
    fpu_op            = r_fpu_op;
    fpu_dbl           = r_fpu_dbl;
    illegal           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          regWrite          = w_dec.reg_write;
          muxA_en           = w_dec.mux_a_en;
          dm_we             = w_dec.dm_we;
          multiplyEn        = w_dec.multiply_en;
          FloatingPointEn   = w_dec.fp_en;
          muxB_en           = w_dec.mux_b_en;
          regWriteAddSelect = w_dec.rwa_sel;
          ALUop             = w_dec.alu_op;
          muxWD3_en         = w_dec.mux_wd3;
          fpu_start         = w_dec.fpu_start;
          illegal           = (w_class == CLS_ILLEGAL);
          if (w_dec.br_eq)      muxPC = zero ? PC_BRANCH : PC_SEQ;
          else if (w_dec.br_ne) muxPC = zero ? PC_SEQ : PC_BRANCH;
          else                  muxPC = w_dec.mux_pc;
          if (w_class == CLS_FPU) begin
            fpu_op  = w_dec.fpu_op;
            fpu_dbl = w_dec.fpu_dbl;
          end
        end
      end
      ST_FPU_WAIT: begin
        illegal = w_timeout;
      end
      ST_FPU_WB: begin
        regWrite          = 1'b1;
        muxWD3_en         = WD3_FPU;
        regWriteAddSelect = RWA_FD;
        FloatingPointEn   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer (MULT_CYCLES=4, FPU_TIMEOUT=8, no DOUBLE).
`timescale 1ns/1ps
module tb_control_sequencer;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [5:0] opcode;
  logic [5:0] functcode;
  logic [4:0] fmt;
  logic       zero;
  logic       fpu_done;
  logic       regWrite, muxA_en, dm_we, multiplyEn, FloatingPointEn;
  logic [1:0] muxB_en, regWriteAddSelect, muxPC;
  logic [2:0] ALUop, muxWD3_en;
  logic       fpu_start, fpu_op, fpu_dbl, stall, illegal;

  always #5 clk = ~clk;

  control_sequencer #(
    .MULT_CYCLES(4), .FPU_TIMEOUT(8), .SUPPORT_DOUBLE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .functcode(functcode), .fmt(fmt), .zero(zero), .fpu_done(fpu_done),
    .regWrite(regWrite), .muxA_en(muxA_en), .dm_we(dm_we), .multiplyEn(multiplyEn),
    .FloatingPointEn(FloatingPointEn), .muxB_en(muxB_en),
    .regWriteAddSelect(regWriteAddSelect), .muxPC(muxPC), .ALUop(ALUop),
    .muxWD3_en(muxWD3_en), .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_dbl(fpu_dbl),
    .stall(stall), .illegal(illegal)
  );

  typedef struct packed {
    logic       rdy, rw, ma, we, me, fe;
    logic [1:0] mb, ra, pc;
    logic [2:0] alu, wd;
    logic       fs, fo, fd, st, il;
  } out_t;

  typedef struct packed {
    logic       v;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] fm;
    logic       z;
    logic       done;
  } stim_t;

  out_t exp_q[$];
  out_t obs_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic m_op   = 1'b0;
  logic m_dbl  = 1'b0;

  function automatic out_t sample();
    out_t o;
    o = {instr_ready, regWrite, muxA_en, dm_we, multiplyEn, FloatingPointEn,
         muxB_en, regWriteAddSelect, muxPC, ALUop, muxWD3_en,
         fpu_start, fpu_op, fpu_dbl, stall, illegal};
    return o;
  endfunction

  function automatic out_t e_idle();
    out_t e;
    e = '0; e.rdy = 1'b1; e.fo = m_op; e.fd = m_dbl;
    return e;
  endfunction

  function automatic out_t e_busy();
    out_t e;
    e = '0; e.st = 1'b1; e.fo = m_op; e.fd = m_dbl;
    return e;
  endfunction

  function automatic stim_t s_ins(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] fm, input logic z);
    stim_t s;
    s = '0; s.v = 1'b1; s.op = op; s.fn = fn; s.fm = fm; s.z = z;
    return s;
  endfunction

  function automatic stim_t s_none(input logic done);
    stim_t s;
    s = '0; s.done = done;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    instr_valid = s.v; opcode = s.op; functcode = s.fn;
    fmt = s.fm; zero = s.z; fpu_done = s.done;
  endtask

  // Drive one cycle: push expectation with the stimulus, capture DUT output mid-cycle
  task automatic step(input stim_t s, input out_t e);
    @(posedge clk); #1;
    drive(s);
    exp_q.push_back(e);
    @(negedge clk);
    obs_q.push_back(sample());
  endtask

  task automatic test_reset();
    out_t o, e;
    int   k = 0;
    reset_n = 1'b0;
    drive(s_ins(OP_RTYPE, FN_ADD, 5'h0, 1'b0));
    repeat (2) @(negedge clk);
    exp_q.push_back('0); obs_q.push_back(sample());
    #1 reset_n = 1'b1;
    #1 exp_q.push_back('0); obs_q.push_back(sample());
    drive(s_none(1'b0));
    step(s_none(1'b0), e_idle());
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL reset[%0d] got=%h want=%h", k, o, e); end
      else $display("ok   reset[%0d] %h", k, o);
      k++;
    end
  endtask

  task automatic test_single();
    out_t o, e;
    int   k = 0;
    e = e_idle(); e.rw = 1; e.mb = 1; e.ra = 2; e.wd = 1; e.alu = 1;
    step(s_ins(OP_RTYPE, FN_SUB, 5'h0, 1'b0), e);
    e.alu = 3; step(s_ins(OP_RTYPE, FN_SLT, 5'h0, 1'b0), e);
    e = e_idle(); e.pc = 2; step(s_ins(OP_RTYPE, FN_JR, 5'h0, 1'b0), e);
    e = e_idle(); e.rw = 1; e.wd = 2; e.ra = 2; step(s_ins(OP_RTYPE, FN_MFHI, 5'h0, 1'b0), e);
    e = e_idle(); e.rw = 1; step(s_ins(OP_LW, 6'h05, 5'h0, 1'b0), e);
    e = e_idle(); e.we = 1; step(s_ins(OP_SW, 6'h00, 5'h0, 1'b0), e);
    e = e_idle(); e.alu = 1; e.mb = 1; step(s_ins(OP_BEQ, 6'h00, 5'h0, 1'b0), e);
    e.pc = 3; step(s_ins(OP_BNE, 6'h00, 5'h0, 1'b0), e);
    e.pc = 0; step(s_ins(OP_BNE, 6'h00, 5'h0, 1'b1), e);
    e = e_idle(); e.rw = 1; e.wd = 1; step(s_ins(OP_ADDI, 6'h00, 5'h0, 1'b0), e);
    e.alu = 2; step(s_ins(OP_XORI, 6'h00, 5'h0, 1'b0), e);
    e = e_idle(); e.pc = 1; step(s_ins(OP_J, 6'h00, 5'h0, 1'b1), e);
    e = e_idle(); e.pc = 1; e.rw = 1; e.ma = 1; e.mb = 2; e.ra = 1;
    step(s_ins(OP_JAL, 6'h00, 5'h0, 1'b0), e);
    step(s_none(1'b1), e_idle());
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL single[%0d] got=%h want=%h", k, o, e); end
      else $display("ok   single[%0d] %h", k, o);
      k++;
    end
  endtask

  task automatic test_back_to_back();
    out_t o, e;
    int   k = 0;
    e = e_idle(); e.rw = 1; e.mb = 1; e.ra = 2; e.wd = 1; e.alu = 0;
    step(s_ins(OP_RTYPE, FN_ADD, 5'h0, 1'b0), e);
    e = e_idle(); e.alu = 1; e.mb = 1; e.pc = 3;
    step(s_ins(OP_BEQ, 6'h00, 5'h0, 1'b1), e);
    step(s_none(1'b0), e_idle());
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL back_to_back[%0d] got=%h want=%h", k, o, e); end
      else $display("ok   back_to_back[%0d] %h", k, o);
      k++;
    end
  endtask

  task automatic test_mult();
    out_t o, e;
    int   k = 0;
    e = e_idle(); e.me = 1;
    step(s_ins(OP_RTYPE, FN_MULT, 5'h0, 1'b0), e);
    for (int c = 1; c <= 3; c++) step(s_ins(OP_RTYPE, FN_MFLO, 5'h0, 1'b0), e_busy());
    e = e_idle(); e.rw = 1; e.wd = 3; e.ra = 2;
    step(s_ins(OP_RTYPE, FN_MFLO, 5'h0, 1'b0), e);
    step(s_none(1'b0), e_idle());
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL mult[%0d] got=%h want=%h", k, o, e); end
      else $display("ok   mult[%0d] %h", k, o);
      k++;
    end
  endtask

  task automatic test_fpu(input logic sub_op);
    out_t o, e;
    int   k = 0;
    m_op = sub_op; m_dbl = 1'b0;
    e = e_idle(); e.fs = 1; e.fe = 1;
    step(s_ins(OP_FR, {5'b0, sub_op}, FMT_SINGLE, 1'b0), e);
    for (int c = 1; c <= 4; c++) step(s_none(1'b0), e_busy());
    step(s_none(1'b1), e_busy());
    e = e_busy(); e.rw = 1; e.wd = 4; e.ra = 3; e.fe = 1;
    step(s_none(1'b0), e);
    step(s_none(1'b1), e_idle());
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL fpu_op%0d[%0d] got=%h want=%h", sub_op, k, o, e); end
      else $display("ok   fpu_op%0d[%0d] %h", sub_op, k, o);
      k++;
    end
  endtask

  task automatic test_illegal();
    out_t o, e;
    int   k = 0;
    e = e_idle(); e.il = 1;
    step(s_ins(OP_FR, FN_FSUB, FMT_DOUBLE, 1'b0), e);
    step(s_none(1'b0), e_idle());
    step(s_ins(6'h3F, 6'h00, 5'h0, 1'b1), e);
    step(s_ins(OP_RTYPE, 6'h3F, 5'h0, 1'b0), e);
    step(s_ins(OP_FR, 6'h02, FMT_SINGLE, 1'b0), e);
    step(s_ins(OP_FR, FN_FADD, 5'h07, 1'b0), e);
    step(s_none(1'b0), e_idle());
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL illegal[%0d] got=%h want=%h", k, o, e); end
      else $display("ok   illegal[%0d] %h", k, o);
      k++;
    end
  endtask

  // done_at_limit=1 asserts fpu_done exactly in the timeout cycle
  task automatic test_timeout(input logic done_at_limit);
    out_t o, e;
    int   k = 0;
    m_op = 1'b0; m_dbl = 1'b0;
    e = e_idle(); e.fs = 1; e.fe = 1;
    step(s_ins(OP_FR, FN_FADD, FMT_SINGLE, 1'b0), e);
    for (int c = 1; c <= 7; c++) step(s_none(1'b0), e_busy());
    if (done_at_limit) begin
      step(s_none(1'b1), e_busy());
      e = e_busy(); e.rw = 1; e.wd = 4; e.ra = 3; e.fe = 1;
      step(s_none(1'b0), e);
    end else begin
      e = e_busy(); e.il = 1;
      step(s_none(1'b0), e);
    end
    step(s_none(1'b0), e_idle());
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL timeout%0d[%0d] got=%h want=%h", done_at_limit, k, o, e); end
      else $display("ok   timeout%0d[%0d] %h", done_at_limit, k, o);
      k++;
    end
  endtask

  task automatic test_reset_mid_fpu();
    out_t o, e;
    int   k = 0;
    m_op = 1'b1; m_dbl = 1'b0;
    e = e_idle(); e.fs = 1; e.fe = 1;
    step(s_ins(OP_FR, FN_FSUB, FMT_SINGLE, 1'b0), e);
    step(s_none(1'b0), e_busy());
    step(s_none(1'b0), e_busy());
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(s_ins(OP_RTYPE, FN_ADD, 5'h0, 1'b0));
    #1 exp_q.push_back('0); obs_q.push_back(sample());
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_op = 1'b0;
    drive(s_none(1'b1));
    #1 exp_q.push_back('0); obs_q.push_back(sample());
    step(s_none(1'b1), e_idle());
    step(s_none(1'b0), e_idle());
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL reset_mid_fpu[%0d] got=%h want=%h", k, o, e); end
      else $display("ok   reset_mid_fpu[%0d] %h", k, o);
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_mult();
    test_fpu(1'b0);
    test_fpu(1'b1);
    test_illegal();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_fpu();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
